// File: rtl/fp_sqrt_iter_pkg.sv
// Shared types for the iterative square-root unit: rounding modes, FSM states,
// operand classes, status-bit positions and the guard/sticky rounding decision.
package fp_sqrt_iter_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RUP = 3'd2,
    RDN = 3'd3,
    RNA = 3'd4
  } round_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } sqrt_state_t;

  typedef enum logic [2:0] {
    CLS_NORM   = 3'd0,
    CLS_ZERO   = 3'd1,
    CLS_INF    = 3'd2,
    CLS_NAN    = 3'd3,
    CLS_NEG    = 3'd4,
    CLS_DENORM = 3'd5
  } fp_class_t;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_NAN     = 2;
  localparam int ST_INEXACT = 5;

  // Increment decision for a positive result; RTZ and RDN both truncate.
  function automatic logic round_gs(input round_t mode, input logic lsb,
                                    input logic guard, input logic sticky);
    case (mode)
      RNE:     round_gs = guard & (sticky | lsb);
      RUP:     round_gs = guard | sticky;
      RNA:     round_gs = guard;
      default: round_gs = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fp_sqrt_iter_step.sv
// One clock's worth of restoring square-root recurrence: consumes two radicand
// bits per root bit and retires bits_per_cycle root bits.
module fp_sqrt_iter_step #(
  parameter int rem_w          = 28,
  parameter int root_w         = 25,
  parameter int bits_per_cycle = 1
) (
  input  logic [rem_w-1:0]            i_rem,
  input  logic [root_w-1:0]           i_root,
  input  logic [2*bits_per_cycle-1:0] i_digits,
  output logic [rem_w-1:0]            o_rem,
  output logic [root_w-1:0]           o_root
);

  logic [rem_w-1:0]  w_rem;
  logic [rem_w-1:0]  w_shift;
  logic [rem_w-1:0]  w_trial;
  logic [root_w-1:0] w_root;

  always_comb begin
    w_rem   = i_rem;
    w_root  = i_root;
    w_shift = '0;
    w_trial = '0;
    for (int k = bits_per_cycle - 1; k >= 0; k--) begin
      w_shift = (w_rem << 2) | rem_w'(i_digits[2*k +: 2]);
      // Trial subtrahend is 4*root + 1; keep it only if the remainder stays >= 0.
      w_trial = rem_w'({w_root, 2'b01});
      if (w_shift >= w_trial) begin
        w_rem  = w_shift - w_trial;
        w_root = (w_root << 1) | root_w'(1);
      end else begin
        w_rem  = w_shift;
        w_root = w_root << 1;
      end
    end
    o_rem  = w_rem;
    o_root = w_root;
  end

endmodule

// File: rtl/fp_sqrt_iter.sv
// Multi-cycle IEEE-754 square root: special operands short-circuit to DONE,
// normal operands run a digit-recurrence engine then a one-cycle round stage.
module fp_sqrt_iter
  import fp_sqrt_iter_pkg::*;
#(
  parameter int sig_width      = 23,
  parameter int ex_width       = 8,
  parameter int bits_per_cycle = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [sig_width+ex_width:0] a,
  input  logic [2:0]                  round,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [sig_width+ex_width:0] z,
  output logic [7:0]                  status,
  output logic                        busy,
  output sqrt_state_t                 o_state
);

  localparam int NITER = (sig_width + 2 + bits_per_cycle - 1) / bits_per_cycle;
  localparam int RB    = NITER * bits_per_cycle;
  localparam int REM_W = RB + 3;
  localparam int RAD_W = 2 * RB;
  localparam int XB    = RB - sig_width - 2;
  localparam int CNT_W = $clog2(NITER + 1);
  localparam logic [CNT_W-1:0]    LAST     = CNT_W'(NITER - 1);
  localparam logic [ex_width:0]   BIAS     = {2'b00, {(ex_width-1){1'b1}}};
  localparam logic [RB-1:0]       LOW_MASK = (RB'(1) << XB) - RB'(1);

  sqrt_state_t r_state, w_next;
  logic [ex_width:0]              r_exp;
  round_t                         r_rnd;
  logic [RAD_W-1:0]               r_rad;
  logic [REM_W-1:0]               r_rem, w_step_rem;
  logic [RB-1:0]                  r_root, w_step_root;
  logic [CNT_W-1:0]               r_cnt;
  logic [sig_width+ex_width:0]    r_z, w_exc_z, w_rnd_z;
  logic [7:0]                     r_status, w_exc_st, w_rnd_st;

  logic                           w_sign;
  logic [ex_width-1:0]            w_exp;
  logic [sig_width-1:0]           w_sig;
  fp_class_t                      w_cls;
  logic signed [ex_width:0]       w_unb;
  logic [ex_width:0]              w_rexp;
  logic [sig_width+1:0]           w_mfx;

  assign w_sign = a[sig_width+ex_width];
  assign w_exp  = a[sig_width+ex_width-1:sig_width];
  assign w_sig  = a[sig_width-1:0];
  assign w_unb  = $signed({1'b0, w_exp}) - $signed(BIAS);
  assign w_rexp = $unsigned(w_unb >>> 1) + BIAS;
  // An odd unbiased exponent moves one factor of two into the radicand.
  assign w_mfx  = w_unb[0] ? {1'b1, w_sig, 1'b0} : {1'b0, 1'b1, w_sig};

  always_comb begin
    if (&w_exp)
      w_cls = (w_sig != '0) ? CLS_NAN : (w_sign ? CLS_NEG : CLS_INF);
    else if (w_exp == '0)
      w_cls = (w_sig != '0) ? CLS_DENORM : CLS_ZERO;
    else
      w_cls = w_sign ? CLS_NEG : CLS_NORM;
  end

  always_comb begin
    w_exc_z  = '0;
    w_exc_st = '0;
    case (w_cls)
      CLS_NAN, CLS_NEG: begin
        w_exc_z          = {1'b0, {ex_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};
        w_exc_st[ST_NAN] = 1'b1;
      end
      CLS_INF: begin
        w_exc_z          = {1'b0, {ex_width{1'b1}}, {sig_width{1'b0}}};
        w_exc_st[ST_INF] = 1'b1;
      end
      CLS_ZERO, CLS_DENORM: begin
        w_exc_z           = {w_sign, {(sig_width+ex_width){1'b0}}};
        w_exc_st[ST_ZERO] = 1'b1;
      end
      default: ;
    endcase
  end

  fp_sqrt_iter_step #(
    .rem_w(REM_W), .root_w(RB), .bits_per_cycle(bits_per_cycle)
  ) u_step (
    .i_rem   (r_rem),
    .i_root  (r_root),
    .i_digits(r_rad[RAD_W-1 -: 2*bits_per_cycle]),
    .o_rem   (w_step_rem),
    .o_root  (w_step_root)
  );

  // Root bits beyond the guard position only matter through the sticky bit.
  logic                 w_guard, w_lsb, w_sticky, w_inc;
  logic [sig_width:0]   w_top;
  logic [sig_width+1:0] w_mant;
  logic [ex_width-1:0]  w_zexp;

  assign w_top    = (sig_width+1)'(r_root >> (XB + 1));
  assign w_guard  = r_root[XB];
  assign w_lsb    = r_root[XB+1];
  assign w_sticky = (r_rem != '0) | ((r_root & LOW_MASK) != '0);
  assign w_inc    = round_gs(r_rnd, w_lsb, w_guard, w_sticky);
  assign w_mant   = {1'b0, w_top} + (sig_width+2)'(w_inc);
  assign w_zexp   = ex_width'(r_exp + (ex_width+1)'(w_mant[sig_width+1]));
  assign w_rnd_z  = {1'b0, w_zexp, sig_width'(w_mant)};

  always_comb begin
    w_rnd_st              = '0;
    w_rnd_st[ST_INEXACT]  = w_guard | w_sticky;
  end

  // Handshake: a transfer happens on a clock edge only when valid, ready and
  // enable are all high; z/status are registered and frozen while out_valid.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (enable && in_valid) w_next = (w_cls == CLS_NORM) ? CALC : DONE;
      end
      CALC:  if (enable && r_cnt == LAST) w_next = ROUND;
      ROUND: if (enable) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (enable && out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_exp    <= '0;
      r_rnd    <= RNE;
      r_rad    <= '0;
      r_rem    <= '0;
      r_root   <= '0;
      r_cnt    <= '0;
      r_z      <= '0;
      r_status <= '0;
    end else if (enable) begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_exp  <= w_rexp;
          r_rnd  <= round_t'(round);
          r_rad  <= {w_mfx, {(RAD_W-sig_width-2){1'b0}}};
          r_rem  <= '0;
          r_root <= '0;
          r_cnt  <= '0;
          if (w_cls != CLS_NORM) begin
            r_z      <= w_exc_z;
            r_status <= w_exc_st;
          end
        end
        CALC: begin
          r_rad  <= r_rad << (2 * bits_per_cycle);
          r_rem  <= w_step_rem;
          r_root <= w_step_root;
          r_cnt  <= r_cnt + 1'b1;
        end
        ROUND: begin
          r_z      <= w_rnd_z;
          r_status <= w_rnd_st;
        end
        default: ;
      endcase
    end
  end

  assign z       = r_z;
  assign status  = r_status;
  assign o_state = r_state;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Bench for fp_sqrt_iter: three instances (1, 2 and 4 root bits per cycle) share
// one stimulus stream and are checked against an integer-sqrt reference model.
`timescale 1ns/1ps
module tb_fp_sqrt_iter;
  import fp_sqrt_iter_pkg::*;

  localparam int W  = 32;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         resetn, enable, in_valid, out_ready;
  logic [W-1:0] a;
  logic [2:0]   rnd;
  logic         rdy[NI], ov[NI], bsy[NI];
  logic [W-1:0] zo[NI];
  logic [7:0]   st[NI];
  sqrt_state_t  fsm[NI];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_st_q[$];
  int           res_lat[NI];
  logic [W-1:0] res_z[NI];
  logic [7:0]   res_st[NI];
  bit           seen[NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fp_sqrt_iter #(.sig_width(23), .ex_width(8), .bits_per_cycle(1 << g)) u_dut (
      .clk(clk), .resetn(resetn), .enable(enable), .in_valid(in_valid),
      .in_ready(rdy[g]), .a(a), .round(rnd), .out_valid(ov[g]),
      .out_ready(out_ready), .z(zo[g]), .status(st[g]), .busy(bsy[g]),
      .o_state(fsm[g])
    );
  end

  function automatic int niter(input int k);
    int b;
    b = 1 << k;
    return (25 + b - 1) / b;
  endfunction

  function automatic longint unsigned isqrt(input longint unsigned n);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 27;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Returns {status, z}.
  function automatic logic [39:0] ref_sqrt(input logic [31:0] x, input logic [2:0] rm);
    int e, u;
    longint unsigned m, n, q, mant;
    bit exact, g, inc;
    e = int'(x[30:23]);
    if (e == 255 && x[22:0] != 0) return {8'h04, 32'h7FC00000};
    if (e == 0) return {8'h01, x[31], 31'd0};
    if (x[31]) return {8'h04, 32'h7FC00000};
    if (e == 255) return {8'h02, 32'h7F800000};
    m = (64'd1 << 23) | 64'(x[22:0]);
    u = e - 127;
    if (u % 2 != 0) begin
      m = m * 2;
      u = u - 1;
    end
    n = m << 25;
    q = isqrt(n);
    exact = (q * q == n);
    g = q[0];
    mant = q >> 1;
    case (rm)
      3'd0:    inc = g && (!exact || mant[0]);
      3'd2:    inc = g || !exact;
      3'd4:    inc = g;
      default: inc = 1'b0;
    endcase
    mant = mant + 64'(inc);
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      u = u + 2;
    end
    return {(g || !exact) ? 8'h20 : 8'h00, 1'b0, 8'(u / 2 + 127), mant[22:0]};
  endfunction

  function automatic bit is_normal(input logic [31:0] x);
    return !x[31] && x[30:23] != 8'h00 && x[30:23] != 8'hFF;
  endfunction

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rdy[0] && rdy[1] && rdy[2]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Drives one operand into all instances and records first out_valid cycle,
  // z and status per instance (cycle 1 = first cycle after the accept edge).
  task automatic run_txn(input logic [31:0] x, input logic [2:0] rm, input bit stall);
    bit ok;
    int cyc;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_wait: in_ready stayed low, required 1");
      return;
    end
    for (int k = 0; k < NI; k++) begin
      seen[k] = 1'b0;
      res_lat[k] = -1;
      res_z[k] = 'x;
      res_st[k] = 'x;
    end
    a = x;
    rnd = rm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (cyc < 300) begin
      for (int k = 0; k < NI; k++) begin
        if (ov[k] && !seen[k]) begin
          seen[k] = 1'b1;
          res_lat[k] = cyc;
          res_z[k] = zo[k];
          res_st[k] = st[k];
        end
      end
      if (seen[0] && seen[1] && seen[2]) break;
      if (stall) enable = (cyc % 2 == 0);
      @(negedge clk);
      cyc++;
    end
    enable = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (rdy[k] !== 1'b1 || ov[k] !== 1'b0 || zo[k] !== '0 || st[k] !== 8'h00 ||
          bsy[k] !== 1'b0 || fsm[k] !== IDLE) begin
        errors++;
        $display("FAIL reset_values[%0d]: in_ready=%b out_valid=%b z=%h status=%h busy=%b, required 1 0 0 0 0",
                 k, rdy[k], ov[k], zo[k], st[k], bsy[k]);
      end
    end
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] t_a[10]  = '{32'h40800000, 32'h40000000, 32'h40000000, 32'hBF800000, 32'h7F800000,
                              32'h80000000, 32'h7FC00001, 32'h00000001, 32'h80000001, 32'hFF800000};
    logic [2:0]  t_rm[10] = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd2};
    logic [31:0] t_z[10]  = '{32'h40000000, 32'h3FB504F3, 32'h3FB504F4, 32'h7FC00000, 32'h7F800000,
                              32'h80000000, 32'h7FC00000, 32'h00000000, 32'h80000000, 32'h7FC00000};
    logic [7:0]  t_st[10] = '{8'h00, 8'h20, 8'h20, 8'h04, 8'h02, 8'h01, 8'h04, 8'h01, 8'h01, 8'h04};
    logic [31:0] ez;
    logic [7:0]  es;
    int          el;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(t_z[i]);
      exp_st_q.push_back(t_st[i]);
      run_txn(t_a[i], t_rm[i], 1'b0);
      ez = exp_q.pop_front();
      es = exp_st_q.pop_front();
      for (int k = 0; k < NI; k++) begin
        el = is_normal(t_a[i]) ? niter(k) + 2 : 1;
        checks++;
        if (res_z[k] !== ez || res_st[k] !== es) begin
          errors++;
          $display("FAIL directed_result[%0d] a=%h rm=%0d: z=%h status=%h, required z=%h status=%h",
                   k, t_a[i], t_rm[i], res_z[k], res_st[k], ez, es);
        end
        checks++;
        if (res_lat[k] !== el) begin
          errors++;
          $display("FAIL directed_latency[%0d] a=%h: %0d cycles, required %0d", k, t_a[i], res_lat[k], el);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, ez;
    logic [2:0]  rm;
    logic [7:0]  es;
    logic [39:0] r;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) x = $urandom;
      else x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      rm = 3'($urandom_range(0, 4));
      r = ref_sqrt(x, rm);
      exp_q.push_back(r[31:0]);
      exp_st_q.push_back(r[39:32]);
      run_txn(x, rm, 1'b0);
      ez = exp_q.pop_front();
      es = exp_st_q.pop_front();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (res_z[k] !== ez || res_st[k] !== es ||
            res_lat[k] !== (is_normal(x) ? niter(k) + 2 : 1)) begin
          errors++;
          $display("FAIL random[%0d] a=%h rm=%0d: z=%h status=%h lat=%0d, required z=%h status=%h",
                   k, x, rm, res_z[k], res_st[k], res_lat[k], ez, es);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int c;
    wait_idle(ok);
    out_ready = 1'b0;
    a = 32'h41100000;
    rnd = 3'd0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    while (!ov[0] && c < 100) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (!ov[0]) begin
      errors++;
      $display("FAIL bp_valid: out_valid=0 after 100 cycles, required 1");
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = 32'h3F800000;
      @(negedge clk);
      checks++;
      if (zo[0] !== 32'h40400000 || st[0] !== 8'h00 || rdy[0] !== 1'b0 || ov[0] !== 1'b1 || bsy[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: z=%h status=%h in_ready=%b out_valid=%b, required 40400000 00 0 1",
                 i, zo[0], st[0], rdy[0], ov[0]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (rdy[k] !== 1'b1 || ov[k] !== 1'b0) begin
        errors++;
        $display("FAIL bp_release[%0d]: in_ready=%b out_valid=%b, required 1 0", k, rdy[k], ov[k]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bsy[0] !== 1'b0 || zo[0] !== 32'h40400000) begin
      errors++;
      $display("FAIL bp_no_second_accept: busy=%b z=%h, required 0 40400000", bsy[0], zo[0]);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ez;
    exp_q.push_back(32'h40400000);
    run_txn(32'h41100000, 3'd0, 1'b1);
    ez = exp_q.pop_front();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (res_z[k] !== ez || res_st[k] !== 8'h00) begin
        errors++;
        $display("FAIL stall_result[%0d]: z=%h status=%h, required %h 00", k, res_z[k], res_st[k], ez);
      end
    end
    checks++;
    if (res_lat[0] !== 2 * (niter(0) + 1) + 1) begin
      errors++;
      $display("FAIL stall_latency: %0d cycles, required %0d", res_lat[0], 2 * (niter(0) + 1) + 1);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [31:0] ez;
    wait_idle(ok);
    a = 32'h40800000;
    rnd = 3'd0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bsy[0] !== 1'b1 || fsm[0] !== CALC) begin
      errors++;
      $display("FAIL midreset_precond: busy=%b, required 1", bsy[0]);
    end
    #2 resetn = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (rdy[k] !== 1'b1 || ov[k] !== 1'b0 || zo[k] !== '0 || st[k] !== 8'h00 || bsy[k] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_values[%0d]: in_ready=%b out_valid=%b z=%h status=%h busy=%b, required 1 0 0 0 0",
                 k, rdy[k], ov[k], zo[k], st[k], bsy[k]);
      end
    end
    @(negedge clk);
    resetn = 1'b1;
    exp_q.push_back(32'h3F800000);
    run_txn(32'h3F800000, 3'd0, 1'b0);
    ez = exp_q.pop_front();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (res_z[k] !== ez || res_st[k] !== 8'h00 || res_lat[k] !== niter(k) + 2) begin
        errors++;
        $display("FAIL after_reset[%0d]: z=%h status=%h lat=%0d, required %h 00 %0d",
                 k, res_z[k], res_st[k], res_lat[k], ez, niter(k) + 2);
      end
    end
  endtask

  initial begin
    resetn = 1'b1;
    enable = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    rnd = 3'd0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_sqrt_iter.md
Name: fp_sqrt_iter

Overview:
- Multi-cycle IEEE-754 square root that replaces the fully combinational significand datapath with a digit-recurrence (restoring) engine.
- The engine retires bits_per_cycle root bits per clock.
- It has valid/ready handshakes on both sides, so it can sit behind an issue queue or arbiter in the FP unit.
- Its rounding, exception and status-byte semantics match the existing FP components.

Parameters:
- sig_width, 23, stored significand bits (hidden 1 excluded).
- ex_width, 8, exponent bits.
- bits_per_cycle, 1, root bits produced per CALC cycle. Legal values are 1, 2, 4.
- Derived localparam NITER = ceil((sig_width+2)/bits_per_cycle).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  global stall. When low, all state holds and no handshake completes.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand (high only in IDLE).
- a  in  sig_width+ex_width+1  operand.
- round  in  3  rounding mode, cast to round_t.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- z  out  sig_width+ex_width+1  result.
- status  out  8  flags: [0] zero, [1] inf, [2] invalid/NaN, [5] inexact; [4:3] and [7:6] are always 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock clk; reset resetn is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, z=0, status=0, busy=0, FSM=IDLE. Reset mid-operation aborts the operation and nothing is emitted.
- Handshake:
  - An input transfer occurs when in_valid & in_ready & enable.
  - An output transfer occurs when out_valid & out_ready & enable.
  - z and status are registered and stay stable while out_valid=1.
- FSM states: IDLE, CALC, ROUND, DONE.
- IDLE:
  - On input transfer, latch sign, exponent, significand and round.
  - Classify the operand as NaN, ±inf, ±0, denormal, negative or normal.
  - Special classes go to DONE with the exception result preloaded.
  - Normal operands go to CALC with the iteration counter cleared.
- CALC:
  - Runs for exactly NITER enabled cycles, retiring bits_per_cycle root bits per cycle.
  - The radicand is {1,sig}, pre-shifted left by 1 when the unbiased exponent is odd.
  - Remainder width is sig_width+5.
  - Sticky = (final remainder != 0).
  - After the last iteration, go to ROUND.
- ROUND (1 cycle):
  - Round sig_width+2 root bits plus sticky per round_t: RNE, RTZ, RUP (+inf), RDN (-inf), RNA. The sign is always positive for these results.
  - If rounding carries out, increment the exponent.
  - Result exponent = ((exp - bias) >>> 1) + bias, computed in ex_width+1 bits. It never overflows or underflows.
  - Set inexact = guard|round|sticky, then go to DONE.
- DONE:
  - out_valid=1.
  - On output transfer, return to IDLE and raise in_ready in the same cycle (in_ready is combinational on the FSM state).
  - With out_ready=0, the block holds indefinitely.
- Latency:
  - Normal operand: input transfer at cycle 0, out_valid at cycle NITER+2.
  - Special operand: out_valid at cycle 1.
- Exceptions:
  - NaN input → canonical qNaN (sign 0, exp all 1s, MSB of sig = 1), status[2]=1.
  - Negative nonzero (including -inf) → qNaN, status[2]=1.
  - +inf → +inf, status[1]=1.
  - ±0 → ±0, status[0]=1.
  - Denormal input is flushed to a zero of the same sign, status[0]=1.
- Stall: enable=0 in any state freezes the counter, the remainder and all outputs.

Decomposition:
- enum_typedefs_pkg:
  - round_t (existing).
  - New fsm enum sqrt_state_t {IDLE, CALC, ROUND, DONE}.
  - New class enum fp_class_t {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN, CLS_NEG, CLS_DENORM}.
- Sub-module sqrt_iter_step, parameterised by width and bits_per_cycle: combinational recurrence for one cycle (remainder, partial root → next remainder, root).
- Reuse round_gs for rounding and exception_sqrt for special-case formatting.

Test Plan:
- a=0x40800000 (4.0), RNE, out_ready=1 → z=0x40000000, status=0x00, out_valid exactly NITER+2 cycles after the accept (27 cycles for the defaults).
- a=0x40000000 (2.0): RNE → z=0x3FB504F3, status[5]=1; RUP → z=0x3FB504F4, status[5]=1.
- Special operands:
  - a=0xBF800000 → z=0x7FC00000, status=0x04.
  - a=0x7F800000 → z=0x7F800000, status=0x02.
  - a=0x80000000 → z=0x80000000, status=0x01.
  - Each of these gives out_valid at cycle 1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → z and status stable, in_ready=0, and a second in_valid is not accepted. Raise out_ready → next-cycle in_ready=1.
- Stall: toggle enable 0/1 every cycle during CALC for a=0x41100000 (9.0) → z=0x40400000, latency doubled.
- Reset: assert resetn=0 mid-CALC → outputs return to reset values immediately. After release, a new operand 0x3F800000 gives z=0x3F800000.
- Repeat the first, second and third scenarios with bits_per_cycle=2 and 4 → same z and status, latency NITER+2.
